// File: rtl/store_align_queue_pkg.sv
// Shared CPU encodings and bundles for the store path.
// Store-type and load-select codes live side by side.
package store_align_queue_pkg;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  localparam logic [2:0] ST_SB  = 3'd0;
  localparam logic [2:0] ST_SH  = 3'd1;
  localparam logic [2:0] ST_SW  = 3'd2;
  localparam logic [2:0] ST_SWL = 3'd5;
  localparam logic [2:0] ST_SWR = 3'd6;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } st_entry_t;

endpackage

// File: rtl/store_align_queue_if.sv
// Store request / memory write / address-error bundle.
// slave = queue side, master = driver side.
interface store_align_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_strb;
  logic        ade_valid;
  logic [31:0] ade_addr;

  modport slave (
    input  in_valid, in_addr, in_data, in_sel,
    input  flush, out_ready,
    output in_ready, out_valid, out_addr,
    output out_wdata, out_strb,
    output ade_valid, ade_addr
  );

  modport master (
    output in_valid, in_addr, in_data, in_sel,
    output flush, out_ready,
    input  in_ready, out_valid, out_addr,
    input  out_wdata, out_strb,
    input  ade_valid, ade_addr
  );
endinterface

// File: rtl/store_b_w_e_gen.sv
// Store lane alignment: byte strobe, lane data and
// address-error flag, purely combinational.
module store_b_w_e_gen
  import store_align_queue_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [2:0]  sel,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic        ade
);

  logic [1:0] b;
  logic [1:0] nb;

  assign b  = addr ^ {2{BIG_ENDIAN}};
  assign nb = 2'd3 - b;

  // decode store type into strobe/data/error
  always_comb begin
    strb  = 4'b1111;
    wdata = data;
    ade   = 1'b0;
    unique case (1'b1)
      sel == ST_SB: begin
        strb  = 4'b0001 << b;
        wdata = {4{data[7:0]}};
      end
      sel == ST_SH: begin
        strb  = b[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
        ade   = addr[0];
      end
      sel == ST_SWL: begin
        strb  = 4'b1111 >> nb;
        wdata = data >> {nb, 3'b000};
      end
      sel == ST_SWR: begin
        strb  = 4'b1111 << b;
        wdata = data << {b, 3'b000};
      end
      default: begin
        strb  = 4'b1111;
        wdata = data;
        ade   = addr != 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/store_align_queue.sv
// Aligns stores and queues them in a 2-deep FIFO
// toward memory; misaligned stores raise ade instead.
module store_align_queue
  import store_align_queue_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  store_align_queue_if.slave    bus
);

  logic [3:0]  al_strb;
  logic [31:0] al_wdata;
  logic        al_ade;

  store_b_w_e_gen #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_gen (
    .addr  (bus.in_addr[1:0]),
    .data  (bus.in_data),
    .sel   (bus.in_sel),
    .strb  (al_strb),
    .wdata (al_wdata),
    .ade   (al_ade)
  );

  st_entry_t  mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       acc;
  logic       push;
  logic       pop;
  logic       ade_q;
  logic [31:0] ade_addr_q;
  st_entry_t  head;

  assign bus.in_ready = !rst && !bus.flush
                        && (count != 2'd2);
  assign acc  = bus.in_valid && bus.in_ready;
  assign push = acc && !al_ade;
  assign pop  = bus.out_valid && bus.out_ready;

  assign head          = mem[rd_ptr];
  assign bus.out_valid = !rst && (count != 2'd0);
  assign bus.out_addr  = {head.waddr, 2'b00};
  assign bus.out_wdata = head.wdata;
  assign bus.out_strb  = head.strb;
  assign bus.ade_valid = !rst && ade_q;
  assign bus.ade_addr  = ade_addr_q;

  // occupancy and pointers; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        waddr: bus.in_addr[31:2],
        wdata: al_wdata,
        strb:  al_strb
      };
    end
  end

  // one-cycle address-error pulse with held address
  always_ff @(posedge clk) begin
    if (rst) begin
      ade_q      <= 1'b0;
      ade_addr_q <= 32'd0;
    end else begin
      ade_q <= acc && al_ade;
      if (acc && al_ade) ade_addr_q <= bus.in_addr;
    end
  end

endmodule
